// File: rtl/mem_req_unit_pkg.sv
// Shared definitions for the data-memory request path: FSM state encoding,
// default timeout and the big-endian byte-lane convention used by memory models.
package mem_req_unit_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_DUMP   = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  // Big-endian lanes: the even (lower) address holds bits 15:8,
  // the following odd address holds bits 7:0.
  function automatic logic [7:0] be_lane(input logic [DATA_W-1:0] word, input logic lsb);
    return lsb ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating access-duration counter; flags the cycle whose increment
// would reach TIMEOUT so the FSM can abort in that same cycle.
module mem_timeout_ctr
  import mem_req_unit_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Count enabled cycles from zero, holding at TIMEOUT instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CW'(TIMEOUT))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = i_en && (r_cnt >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_req_unit.sv
// Initiator for the 16-bit byte-addressable data memory: one load/store at a
// time, stall/multi-cycle aware, timeout-protected, one dump pulse on halt.
module mem_req_unit
  import mem_req_unit_pkg::*;
#(
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic              halt,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_createdump,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_stall,
  input  logic              mem_done,
  input  logic              mem_err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_halt_pend;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic w_halt;
  logic w_accept;
  logic w_misalign;
  logic w_cnt_en;
  logic w_cnt_clr;
  logic w_expired;
  logic w_capture;
  logic w_tmo;

  // A halt seen this cycle already blocks acceptance, so halt beats req_valid.
  assign w_halt     = r_halt_pend | halt;
  assign w_accept   = (r_state == ST_IDLE) & ~w_halt & req_valid;
  assign w_misalign = ALIGN_CHECK & req_addr[0];
  assign w_cnt_en   = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign w_cnt_clr  = w_accept & ~w_misalign;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  // State register and sticky halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_halt_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (halt) begin
        r_halt_pend <= 1'b1;
      end
    end
  end

  // Latch request fields on accept; capture the response on completion or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_wr    <= req_wr;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_rdata <= '0;
      r_err   <= w_misalign;
    end else if (w_capture) begin
      r_rdata <= (r_wr | mem_err) ? '0 : mem_rdata;
      r_err   <= mem_err;
    end else if (w_tmo) begin
      r_rdata <= '0;
      r_err   <= 1'b1;
    end
  end

  // Next-state and output decode; stall outranks done, done outranks timeout.
  always_comb begin
    w_state_nxt    = r_state;
    w_capture      = 1'b0;
    w_tmo          = 1'b0;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_err       = 1'b0;
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_createdump = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_halt) begin
          w_state_nxt = ST_DUMP;
        end else if (w_accept) begin
          w_state_nxt = w_misalign ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_stall) begin
          if (w_expired) begin
            w_state_nxt = ST_RESP;
            w_tmo       = 1'b1;
          end
        end else if (mem_done) begin
          w_state_nxt = ST_RESP;
          w_capture   = 1'b1;
        end else if (w_expired) begin
          w_state_nxt = ST_RESP;
          w_tmo       = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_done) begin
          w_state_nxt = ST_RESP;
          w_capture   = 1'b1;
        end else if (w_expired) begin
          w_state_nxt = ST_RESP;
          w_tmo       = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DUMP:   w_state_nxt = ST_HALTED;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_IDLE;
    endcase

    // Outputs stay quiet for the whole time reset is held.
    if (!rst) begin
      case (r_state)
        ST_IDLE: req_ready = ~w_halt;
        ST_ISSUE: begin
          mem_enable = 1'b1;
          mem_wr     = r_wr;
          mem_addr   = r_addr;
          mem_wdata  = r_wdata;
        end
        ST_WAIT: begin
          mem_wr    = r_wr;
          mem_addr  = r_addr;
          mem_wdata = r_wdata;
        end
        ST_RESP: begin
          resp_valid = 1'b1;
          resp_rdata = r_rdata;
          resp_err   = r_err;
        end
        ST_DUMP: mem_createdump = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_unit.sv
// Bench for mem_req_unit: transaction-timeline reference model, randomized
// memory behaviour and a per-cycle compare of every DUT output.
module tb_mem_req_unit;
  import mem_req_unit_pkg::*;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [15:0] resp_rdata;
  logic        halt;
  logic        mem_enable, mem_wr, mem_createdump;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_stall, mem_done, mem_err;

  mem_req_unit #(.TIMEOUT(TO), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .halt(halt),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_createdump(mem_createdump),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_done(mem_done),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_dump = 0;

  // expected outputs for the current cycle
  logic        e_req_ready, e_resp_valid, e_resp_err;
  logic        e_mem_enable, e_mem_wr, e_mem_createdump;
  logic [15:0] e_resp_rdata, e_mem_addr, e_mem_wdata;

  // model state
  bit          m_hp;
  logic [7:0]  bmem [0:511];

  // observations of the last transaction
  int          obs_first, obs_en, obs_resp;
  logic [15:0] obs_rdata;
  logic        obs_err;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("req_ready",      16'(req_ready),      16'(e_req_ready));
    cmp("resp_valid",     16'(resp_valid),     16'(e_resp_valid));
    cmp("resp_rdata",     resp_rdata,          e_resp_rdata);
    cmp("resp_err",       16'(resp_err),       16'(e_resp_err));
    cmp("mem_enable",     16'(mem_enable),     16'(e_mem_enable));
    cmp("mem_wr",         16'(mem_wr),         16'(e_mem_wr));
    cmp("mem_addr",       mem_addr,            e_mem_addr);
    cmp("mem_wdata",      mem_wdata,           e_mem_wdata);
    cmp("mem_createdump", 16'(mem_createdump), 16'(e_mem_createdump));
    if (mem_createdump) n_dump++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_exp();
    e_req_ready = 0; e_resp_valid = 0; e_resp_err = 0; e_resp_rdata = 0;
    e_mem_enable = 0; e_mem_wr = 0; e_mem_addr = 0; e_mem_wdata = 0;
    e_mem_createdump = 0;
  endtask

  task automatic noise_mem();
    mem_stall = 1'($urandom); mem_done = 1'($urandom);
    mem_err = 1'($urandom);   mem_rdata = 16'($urandom);
  endtask

  task automatic noise_req();
    req_wr = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    for (int i = 0; i < n; i++) begin
      req_valid = 1'($urandom); noise_req(); halt = 1'($urandom);
      resp_ready = 1'($urandom); noise_mem();
      zero_exp();
      tick();
    end
    rst = 0;
    m_hp = 0;
  endtask

  task automatic idle_cycle(input bit rv, input bit h);
    rst = 0; req_valid = rv; noise_req(); halt = h;
    resp_ready = 1'($urandom); noise_mem();
    zero_exp();
    e_req_ready = !(m_hp || h);
    tick();
    m_hp = m_hp | h;
  endtask

  task automatic quiet_cycle(input bit dump);
    rst = 0; req_valid = 1'($urandom); noise_req(); halt = 1'($urandom);
    resp_ready = 1'($urandom); noise_mem();
    zero_exp();
    e_mem_createdump = dump;
    tick();
  endtask

  // unit is idle with halt pending (need_idle) or has just seen halt in idle
  task automatic halt_finish(input bit need_idle, input int n);
    if (need_idle) idle_cycle(1'($urandom), 0);
    quiet_cycle(1);
    for (int i = 0; i < n; i++) quiet_cycle(0);
  endtask

  // One request: s stall cycles in ISSUE, w further cycles until mem_done
  // (w<0: never), bp cycles of resp back-pressure, optional halt/rst at cycle t.
  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input int s, input int w, input bit merr, input int bp,
                         input int halt_t, input int abort_t);
    bit mis, tmo, errx, fin;
    int d, r, ai;
    logic [15:0] rd_exp, ld;
    mis = addr[0];
    ai  = int'(addr[8:0]);
    d   = (w < 0) ? 1000 : s + 1 + w;
    tmo = !mis && (d > TO);
    r   = mis ? 1 : (tmo ? TO + 1 : d + 1);
    errx = mis | tmo | merr;
    rd_exp = 16'h0;
    obs_first = -1; obs_en = 0; obs_resp = 0; obs_rdata = 0; obs_err = 0;
    fin = 0;
    // accept cycle
    rst = 0; halt = 0; req_valid = 1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    resp_ready = 1'($urandom); noise_mem();
    zero_exp();
    e_req_ready = 1;
    tick();
    for (int t = 1; t < 200 && !fin; t++) begin
      rst = (t == abort_t);
      halt = (t == halt_t);
      req_valid = 1'($urandom); noise_req();
      if (!mis && t < r) begin
        mem_stall = (t <= s);
        mem_done  = (t == d);
        mem_err   = (t == d) ? merr : 1'($urandom);
        mem_rdata = 16'($urandom);
        if (t == d) begin
          ld = {bmem[ai], bmem[ai + 1]};
          if (!wr) mem_rdata = ld;
          rd_exp = (wr || merr) ? 16'h0 : ld;
          if (wr && !merr && !rst) begin
            bmem[ai]     = be_lane(wdata, 1'b0);
            bmem[ai + 1] = be_lane(wdata, 1'b1);
          end
        end
      end else begin
        noise_mem();
      end
      resp_ready = (t >= r) ? (t >= r + bp) : 1'($urandom);
      zero_exp();
      if (!rst) begin
        e_mem_enable = !mis && (t <= s + 1) && (t < r);
        if (!mis && t < r) begin
          e_mem_wr = wr; e_mem_addr = addr; e_mem_wdata = wdata;
        end
        if (t >= r) begin
          e_resp_valid = 1; e_resp_rdata = rd_exp; e_resp_err = errx;
        end
      end
      #2;
      if (resp_valid) begin
        if (obs_first < 0) obs_first = t;
        obs_resp++;
        obs_rdata = resp_rdata;
        obs_err = resp_err;
      end
      if (mem_enable) obs_en++;
      tick();
      if (rst) begin
        rst = 0; m_hp = 0; fin = 1;
      end else begin
        m_hp = m_hp | halt;
        if (t >= r && resp_ready) fin = 1;
      end
    end
  endtask

  initial begin
    rst = 1; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 0; halt = 0; mem_rdata = 0; mem_stall = 0; mem_done = 0; mem_err = 0;
    m_hp = 0;
    zero_exp();
    for (int i = 0; i < 512; i++) bmem[i] = 8'h00;
    bmem[9'h100] = 8'h12;
    bmem[9'h101] = 8'h34;

    do_reset(3);

    // zero-latency store then load
    run_txn(1, 16'h0010, 16'hBEEF, 0, 0, 0, 0, 0, 0);
    cmp("lit_st_lat", 16'(obs_first), 16'd2);
    cmp("lit_st_en",  16'(obs_en),    16'd1);
    run_txn(0, 16'h0010, 16'h0000, 0, 0, 0, 0, 0, 0);
    cmp("lit_ld_lat",  16'(obs_first), 16'd2);
    cmp("lit_ld_en",   16'(obs_en),    16'd1);
    cmp("lit_ld_data", obs_rdata,      16'hBEEF);
    cmp("lit_ld_err",  16'(obs_err),   16'd0);

    // misaligned load
    run_txn(0, 16'h0011, 16'h0000, 0, 0, 0, 0, 0, 0);
    cmp("lit_mis_en",   16'(obs_en),  16'd0);
    cmp("lit_mis_err",  16'(obs_err), 16'd1);
    cmp("lit_mis_data", obs_rdata,    16'h0000);

    // stalling memory: 3 stall cycles, done 2 cycles later
    run_txn(0, 16'h0100, 16'h0000, 3, 2, 0, 0, 0, 0);
    cmp("lit_stall_en",   16'(obs_en),    16'd4);
    cmp("lit_stall_lat",  16'(obs_first), 16'd7);
    cmp("lit_stall_data", obs_rdata,      16'h1234);

    // timeout, then a normal access
    run_txn(0, 16'h0020, 16'h0000, 0, -1, 0, 0, 0, 0);
    cmp("lit_to_lat",  16'(obs_first), 16'd9);
    cmp("lit_to_err",  16'(obs_err),   16'd1);
    cmp("lit_to_data", obs_rdata,      16'h0000);
    run_txn(1, 16'h0020, 16'hA55A, 1, 1, 0, 0, 0, 0);
    cmp("lit_after_to_lat", 16'(obs_first), 16'd4);
    cmp("lit_after_to_err", 16'(obs_err),   16'd0);

    // back-pressure for 5 cycles
    run_txn(0, 16'h0020, 16'h0000, 0, 1, 0, 5, 0, 0);
    cmp("lit_bp_cycles", 16'(obs_resp), 16'd6);
    cmp("lit_bp_data",   obs_rdata,     16'hA55A);

    // reset in the middle of an access, then resume
    run_txn(0, 16'h0030, 16'h0000, 2, 3, 0, 0, 0, 3);
    idle_cycle(0, 0);
    run_txn(0, 16'h0100, 16'h0000, 0, 0, 0, 0, 0, 0);

    // halt during WAIT: access completes, one dump pulse, halted until reset
    n_dump = 0;
    run_txn(0, 16'h0100, 16'h0000, 0, 3, 0, 0, 2, 0);
    cmp("lit_halt_data", obs_rdata, 16'h1234);
    halt_finish(1, 6);
    cmp("lit_dump_once", 16'(n_dump), 16'd1);
    do_reset(2);
    idle_cycle(0, 0);

    // halt and req_valid in the same idle cycle
    idle_cycle(1, 1);
    halt_finish(0, 4);
    do_reset(1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int k, s, w, bp, ht, at, gap;
      bit wr, merr;
      logic [15:0] addr;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle(0, 0);
      k    = $urandom_range(0, 99);
      wr   = 1'($urandom);
      addr = {7'd0, 8'($urandom_range(0, 255)), 1'b0};
      if ($urandom_range(0, 9) == 0) addr[0] = 1'b1;
      s    = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 10) : $urandom_range(0, 3);
      w    = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
      merr = ($urandom_range(0, 7) == 0);
      bp   = $urandom_range(0, 3);
      at   = (k < 4)  ? $urandom_range(1, 6) : 0;
      ht   = (k >= 96) ? $urandom_range(1, 5) : 0;
      run_txn(wr, addr, 16'($urandom), s, w, merr, bp, ht, at);
      if (m_hp) begin
        halt_finish(1, $urandom_range(1, 4));
        do_reset($urandom_range(1, 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_req_unit.md
# mem_req_unit

Initiator side of the 16-bit, byte-addressable data-memory interface. It sits between the processor's memory stage and the data memory, which may be single-cycle or multi-cycle/stalling. It accepts one load/store request at a time and drives the memory enable/write/address/data. It waits for completion with a timeout, returns read data or an error, and on halt issues a single memory-dump pulse before going quiet.

## Interface
- TIMEOUT, 64: max cycles from ISSUE entry to mem_done before the access is aborted with error.
- ALIGN_CHECK, 1: when 1, odd addresses are rejected with error and no memory access.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_wr  in  1  1 = store, 0 = load.
- req_addr  in  16  byte address.
- req_wdata  in  16  store data, big-endian (bits 15:8 go to addr, 7:0 to addr+1).
- resp_valid  out  1  response available.
- resp_ready  in  1  pipeline consumes response.
- resp_rdata  out  16  load data; 0 for stores and errors.
- resp_err  out  1  misaligned, memory error or timeout.
- halt  in  1  processor halt; sticky once seen.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  memory write select.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_createdump  out  1  dump request to memory.
- mem_rdata  in  16  memory read data.
- mem_stall  in  1  memory refuses this cycle's access; must re-present it.
- mem_done  in  1  access complete; mem_rdata valid this cycle.
- mem_err  in  1  qualifies mem_done; access faulted.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DUMP, HALTED.
- IDLE:
  - req_ready = ~halt_pending.
  - On req_valid & req_ready: latch wr/addr/wdata.
  - If ALIGN_CHECK & addr[0]: go to RESP with err=1. No memory strobe.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_enable=1; mem_wr/mem_addr/mem_wdata come from the latched fields.
  - mem_stall=1: stay in ISSUE and re-present identically.
  - mem_done=1 (zero-latency memory): capture mem_rdata if load, err=mem_err, go to RESP.
  - Otherwise go to WAIT.
- WAIT:
  - mem_enable=0; hold mem_addr/mem_wr/mem_wdata.
  - On mem_done: capture as in ISSUE and go to RESP.
- Timeout: a counter clears on ISSUE entry and increments every ISSUE/WAIT cycle. When it reaches TIMEOUT without mem_done, go to RESP with err=1 and rdata=0.
- RESP:
  - resp_valid=1; resp_rdata/resp_err are held stable until resp_ready.
  - On resp_ready: go to IDLE.
- halt:
  - Sets halt_pending on any cycle; it clears only on rst.
  - An in-flight access always completes through RESP.
  - IDLE with halt_pending goes to DUMP.
  - halt and req_valid in the same IDLE cycle: halt wins and the request is not accepted.
- DUMP: mem_createdump=1 for exactly one cycle, mem_enable=0, then go to HALTED.
- HALTED: req_ready=0, all mem outputs 0, no further strobes until rst.
- Memory inputs are ignored outside ISSUE/WAIT. A stray mem_done in other states has no effect.
- Counter width is clog2(TIMEOUT+1); it saturates and never wraps.

## Timing
- While rst is high: state=IDLE, halt_pending=0, counter=0, latched fields=0. All outputs are 0, including req_ready.
- After reset: req_ready=1 in the first cycle following rst deassertion.
- rst mid-access: the access is abandoned and all outputs are 0 in the next cycle. No dump is issued.
- Outputs decode combinationally from state and registered fields; there is no combinational path from req_* to mem_*.
- Zero-latency memory: accept at edge N, mem_enable high in cycle N+1, resp_valid in cycle N+2.
- Latency with a stalling memory is 2 + stall cycles + wait cycles.
- Throughput: one access per 3 cycles at best. A new request can be accepted in the cycle after the RESP handshake.

## Structure
- Shared package/include holds the state encoding (3 bits), the default TIMEOUT, and the big-endian byte-lane convention shared with the memory models.
- One natural sub-module: mem_timeout_ctr (clear, enable, saturating count, expired flag).
- The FSM and field latches stay in mem_req_unit.

## Test plan
- Zero-latency memory: store 0xBEEF @0x0010, then load @0x0010. mem_enable pulses 1 cycle each; load returns resp_rdata=0xBEEF, err=0, resp_valid 2 cycles after accept.
- Misaligned load @0x0011 with ALIGN_CHECK=1: mem_enable never asserts; resp_valid with err=1, rdata=0.
- Stalling memory, load @0x0100:
  - mem_stall for 3 cycles keeps mem_enable high with a stable address.
  - mem_done 2 cycles later with 0x1234 gives rdata=0x1234.
- Timeout with TIMEOUT=8: mem_done never arrives, so resp_err=1 exactly 8 cycles after ISSUE entry. The next request is accepted normally.
- Back-pressure: resp_ready low for 5 cycles holds resp_valid/rdata stable and keeps req_ready=0.
- halt during WAIT: the access completes and responds; then mem_createdump is high for exactly 1 cycle; then HALTED with req_ready=0 until rst. rst returns the unit to IDLE.
